// File: rtl/noc_frame_tx_if.sv
// noc_frame_tx_if
//   Packet-side handshake and link-side outputs of the NoC frame transmitter.
//   master : packet source (drives i_valid / destination / payload, observes link)
//   slave  : noc_frame_tx itself
//   Signals:
//     i_valid       packet request
//     o_ready       transmitter idle, a packet can be accepted this cycle
//     i_x_dest      destination X (high nibble of the dest byte)
//     i_y_dest      destination Y (low nibble of the dest byte)
//     i_payload     packet data, sent MSB-first
//     o_byte        registered link byte, one per clock
//     o_busy        frame in progress
//     o_frame_done  one-cycle pulse while o_byte carries the closing flag
interface noc_frame_tx_if #(
  parameter int PAYLOAD_BYTES = 4
) ();
  logic                         i_valid;
  logic                         o_ready;
  logic [3:0]                   i_x_dest;
  logic [3:0]                   i_y_dest;
  logic [8*PAYLOAD_BYTES-1:0]   i_payload;
  logic [7:0]                   o_byte;
  logic                         o_busy;
  logic                         o_frame_done;

  modport master (
    output i_valid, i_x_dest, i_y_dest, i_payload,
    input  o_ready, o_byte, o_busy, o_frame_done
  );

  modport slave (
    input  i_valid, i_x_dest, i_y_dest, i_payload,
    output o_ready, o_byte, o_busy, o_frame_done
  );
endinterface

// File: rtl/noc_frame_tx.sv
// noc_frame_tx
//   Serialises one NoC packet ({x_dest, y_dest} byte + payload) per transaction
//   into the byte-stream link framing:
//     FLAG, byte-stuffed body (dest byte, payload MSB-first), FLAG, IDLE gap.
//   Body bytes equal to FLAG_BYTE or ESC_BYTE are sent as ESC_BYTE followed by
//   the byte XOR ESC_XOR. One link byte leaves every clock.
//   Ports:
//     clk  system clock
//     rst  asynchronous active-high reset; aborts any frame in progress
//     bus  noc_frame_tx_if.slave (valid/ready packet input, link byte output,
//          busy and frame_done status)
module noc_frame_tx #(
  parameter int         PAYLOAD_BYTES = 4,
  parameter logic [7:0] FLAG_BYTE     = 8'h7E,
  parameter logic [7:0] ESC_BYTE      = 8'h7D,
  parameter logic [7:0] ESC_XOR       = 8'h20,
  parameter logic [7:0] IDLE_BYTE     = 8'h00
) (
  input  logic           clk,
  input  logic           rst,
  noc_frame_tx_if.slave  bus
);

  localparam int NB    = 1 + PAYLOAD_BYTES;
  localparam int SR_W  = 8 * NB;
  localparam int IDX_W = $clog2(PAYLOAD_BYTES + 2);

  typedef enum logic [2:0] {
    IDLE,
    SOF,
    BODY,
    BODY_ESC,
    EOF,
    GAP
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic              esc_pend;
  logic [7:0]        link_byte;
  logic              frame_done;
  logic [SR_W-1:0]   shreg;

  logic              accept;
  logic [7:0]        cur;
  logic              special;
  logic              body_done;
  logic              in_body;
  logic              esc_second;
  logic              consume;

  // The state register describes the byte currently on the wire; every edge
  // picks the next byte, so o_byte is registered together with the state.
  assign accept     = bus.i_valid && (state == IDLE);
  assign cur        = shreg[SR_W-1 -: 8];
  assign special    = (cur == FLAG_BYTE) || (cur == ESC_BYTE);
  assign body_done  = (idx == IDX_W'(NB));
  assign in_body    = (state == SOF) || (state == BODY) || (state == BODY_ESC);
  // The escape prefix is on the wire; the next byte is the XORed body byte.
  assign esc_second = (state == BODY) && esc_pend;
  // A body byte is consumed when it is emitted plain or as the second half of
  // an escape pair; the prefix alone does not consume it.
  assign consume    = esc_second || (in_body && !body_done && !special);

  // Packet bytes, top byte is the next one to send. Data only, no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg <= {bus.i_x_dest, bus.i_y_dest, bus.i_payload};
    end else if (consume) begin
      shreg <= shreg << 8;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      esc_pend   <= 1'b0;
      link_byte  <= IDLE_BYTE;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          link_byte <= IDLE_BYTE;
          if (accept) begin
            state     <= SOF;
            idx       <= '0;
            esc_pend  <= 1'b0;
            link_byte <= FLAG_BYTE;
          end
        end
        SOF, BODY, BODY_ESC: begin
          if (esc_second) begin
            state     <= BODY_ESC;
            link_byte <= cur ^ ESC_XOR;
            idx       <= idx + IDX_W'(1);
            esc_pend  <= 1'b0;
          end else if (body_done) begin
            state      <= EOF;
            link_byte  <= FLAG_BYTE;
            frame_done <= 1'b1;
          end else if (special) begin
            state     <= BODY;
            link_byte <= ESC_BYTE;
            esc_pend  <= 1'b1;
          end else begin
            state     <= BODY;
            link_byte <= cur;
            idx       <= idx + IDX_W'(1);
          end
        end
        EOF: begin
          state     <= GAP;
          link_byte <= IDLE_BYTE;
        end
        GAP: begin
          state     <= IDLE;
          link_byte <= IDLE_BYTE;
        end
        default: begin
          state     <= IDLE;
          link_byte <= IDLE_BYTE;
        end
      endcase
    end
  end

  assign bus.o_ready      = (state == IDLE);
  assign bus.o_busy       = (state != IDLE);
  assign bus.o_byte       = link_byte;
  assign bus.o_frame_done = frame_done;

endmodule

// File: tb/tb_noc_frame_tx.sv
module tb_noc_frame_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  noc_frame_tx_if #(.PAYLOAD_BYTES(4)) bus ();

  noc_frame_tx #(.PAYLOAD_BYTES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Expected link activity, one entry per clock: byte, frame_done, ready.
  logic [7:0] exp_b[$];
  logic       exp_d[$];
  logic       exp_r[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic void push(input logic [7:0] b, input logic d, input logic r);
    exp_b.push_back(b);
    exp_d.push_back(d);
    exp_r.push_back(r);
  endfunction

  // Reference framing: flag, stuffed dest + payload MSB-first, flag, gap.
  function automatic void push_frame(input logic [7:0] dest, input logic [31:0] pl);
    logic [7:0] raw[5];
    raw[0] = dest;
    for (int i = 0; i < 4; i++) raw[i+1] = pl[31-8*i -: 8];
    push(8'h7E, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (raw[i] == 8'h7E || raw[i] == 8'h7D) begin
        push(8'h7D, 1'b0, 1'b0);
        push(raw[i] ^ 8'h20, 1'b0, 1'b0);
      end else begin
        push(raw[i], 1'b0, 1'b0);
      end
    end
    push(8'h7E, 1'b1, 1'b0);
    push(8'h00, 1'b0, 1'b0);
  endfunction

  // Literal wire sequence including trailing gap byte; closing flag is second to last.
  function automatic void push_lit(input logic [7:0] seq[$]);
    for (int i = 0; i < seq.size(); i++)
      push(seq[i], (i == seq.size() - 2), 1'b0);
  endfunction

  function automatic void push_idle();
    push(8'h00, 1'b0, 1'b1);
  endfunction

  function automatic logic [7:0] rnd_byte();
    case ($urandom_range(0, 4))
      0: return 8'h7E;
      1: return 8'h7D;
      2: return 8'h00;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic drive(input logic [7:0] dest, input logic [31:0] pl);
    bus.i_valid   = 1'b1;
    bus.i_x_dest  = dest[7:4];
    bus.i_y_dest  = dest[3:0];
    bus.i_payload = pl;
  endtask

  task automatic step(input string tag);
    logic [7:0] b;
    logic d, r;
    @(negedge clk);
    b = exp_b.pop_front();
    d = exp_d.pop_front();
    r = exp_r.pop_front();
    chk({tag, "_byte"},  {24'd0, bus.o_byte}, {24'd0, b});
    chk({tag, "_done"},  {31'd0, bus.o_frame_done}, {31'd0, d});
    chk({tag, "_ready"}, {31'd0, bus.o_ready}, {31'd0, r});
    chk({tag, "_busy"},  {31'd0, bus.o_busy}, {31'd0, ~r});
  endtask

  task automatic drain(input string tag);
    while (exp_b.size() > 0) step(tag);
  endtask

  initial begin
    logic [7:0] lit[$];
    logic [7:0] dest;
    logic [31:0] pl;
    int n1;

    bus.i_valid   = 1'b0;
    bus.i_x_dest  = 4'h0;
    bus.i_y_dest  = 4'h0;
    bus.i_payload = 32'h0;

    #1 rst = 1'b1;
    #1;
    chk("reset_byte",  {24'd0, bus.o_byte}, 32'h00);
    chk("reset_ready", {31'd0, bus.o_ready}, 32'd1);
    chk("reset_busy",  {31'd0, bus.o_busy}, 32'd0);
    chk("reset_done",  {31'd0, bus.o_frame_done}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Basic frame
    drive(8'h10, 32'h12345678);
    lit = '{8'h7E, 8'h10, 8'h12, 8'h34, 8'h56, 8'h78, 8'h7E, 8'h00};
    push_lit(lit);
    push_idle();
    step("basic");
    bus.i_valid = 1'b0;
    drain("basic");

    // Escaping
    drive(8'h7E, 32'h7D007E01);
    lit = '{8'h7E, 8'h7D, 8'h5E, 8'h7D, 8'h5D, 8'h00, 8'h7D, 8'h5E, 8'h01, 8'h7E, 8'h00};
    push_lit(lit);
    push_idle();
    step("escape");
    bus.i_valid = 1'b0;
    drain("escape");

    // Worst-case stuffing: 12 bytes flag to flag
    drive(8'h7D, 32'h7E7E7E7E);
    lit = '{8'h7E, 8'h7D, 8'h5D, 8'h7D, 8'h5E, 8'h7D, 8'h5E, 8'h7D, 8'h5E,
            8'h7D, 8'h5E, 8'h7E, 8'h00};
    push_lit(lit);
    push_idle();
    step("worst");
    bus.i_valid = 1'b0;
    drain("worst");

    // Back-to-back with valid held high
    drive(8'hAA, 32'hDEADBEEF);
    push_frame(8'hAA, 32'hDEADBEEF);
    push_idle();
    n1 = exp_b.size();
    push_frame(8'hBB, 32'hCAFEBABE);
    push_idle();
    step("b2b");
    drive(8'hBB, 32'hCAFEBABE);
    repeat (n1 - 1) step("b2b");
    step("b2b");
    bus.i_valid = 1'b0;
    drain("b2b");

    // Request while busy is ignored
    drive(8'h42, 32'h89ABCDEF);
    push_frame(8'h42, 32'h89ABCDEF);
    push_idle();
    push_idle();
    step("busy");
    bus.i_valid = 1'b0;
    step("busy");
    step("busy");
    drive(8'hCC, 32'h01234567);
    step("busy");
    bus.i_valid = 1'b0;
    drain("busy");

    // Reset mid-frame, then a clean frame
    drive(8'h55, 32'h11223344);
    push_frame(8'h55, 32'h11223344);
    step("rstmid");
    bus.i_valid = 1'b0;
    repeat (3) step("rstmid");
    #2 rst = 1'b1;
    #1;
    chk("rstmid_byte",  {24'd0, bus.o_byte}, 32'h00);
    chk("rstmid_ready", {31'd0, bus.o_ready}, 32'd1);
    chk("rstmid_busy",  {31'd0, bus.o_busy}, 32'd0);
    chk("rstmid_done",  {31'd0, bus.o_frame_done}, 32'd0);
    exp_b.delete();
    exp_d.delete();
    exp_r.delete();
    @(negedge clk) rst = 1'b0;
    drive(8'h36, 32'h7E00417D);
    push_frame(8'h36, 32'h7E00417D);
    push_idle();
    step("after_rst");
    bus.i_valid = 1'b0;
    drain("after_rst");

    // Randomized packets against the reference framing
    for (int k = 0; k < 30; k++) begin
      dest = rnd_byte();
      pl   = {rnd_byte(), rnd_byte(), rnd_byte(), rnd_byte()};
      drive(dest, pl);
      push_frame(dest, pl);
      push_idle();
      repeat ($urandom_range(0, 2)) push_idle();
      step("rand");
      bus.i_valid = 1'b0;
      drain("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/noc_frame_tx.md
Name: noc_frame_tx

Overview:
- Serialises one NoC packet per transaction into the router's 8-bit byte-stream link framing. Each packet is a destination plus a 32-bit payload.
- Framing on the wire: 0x7E start flag, byte-stuffed {x_dest, y_dest}, payload MSB-first, 0x7E end flag, 0x00 idle gap.
- Sits at a router output port or PE injection point and drives the link that a router input-port deframer consumes.
- Accepts packets over a valid/ready handshake and emits exactly one byte per clock.

Parameters:
- PAYLOAD_BYTES, 4, payload bytes per frame; payload is sent MSB-first.
- FLAG_BYTE, 8'h7E, frame delimiter.
- ESC_BYTE, 8'h7D, escape prefix.
- ESC_XOR, 8'h20, value XORed into an escaped byte.
- IDLE_BYTE, 8'h00, line value outside a frame.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  packet request.
- o_ready  out  1  block can accept a packet; equals (state==IDLE).
- i_x_dest  in  4  destination X; forms the high nibble of the dest byte.
- i_y_dest  in  4  destination Y; forms the low nibble of the dest byte.
- i_payload  in  8*PAYLOAD_BYTES  packet data.
- o_byte  out  8  link byte, registered.
- o_busy  out  1  frame in progress; equals (state!=IDLE).
- o_frame_done  out  1  one-cycle pulse, registered; high in the cycle o_byte carries the closing flag.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, o_byte=IDLE_BYTE, o_frame_done=0, o_ready=1, o_busy=0.
  - Byte index and escape-pending flag cleared.
  - A frame in progress is aborted and never resumed; the receiver discards the truncated frame.
- Handshake:
  - Accept occurs on a rising edge with i_valid & o_ready.
  - On accept, the shift register captures {x_dest, y_dest, payload}, i.e. 1+PAYLOAD_BYTES bytes.
  - Inputs are ignored whenever o_ready=0; no queuing, no error flag.
- FSM (one o_byte value per cycle):
  - IDLE: o_byte=IDLE_BYTE. On accept -> SOF.
  - SOF: o_byte=FLAG_BYTE -> BODY, index=0.
  - BODY: let b = current byte.
    - If b is FLAG_BYTE or ESC_BYTE: o_byte=ESC_BYTE, then -> BODY_ESC.
    - Otherwise: o_byte=b, advance the index.
    - After the last byte (index==PAYLOAD_BYTES) -> EOF.
  - BODY_ESC: o_byte=b^ESC_XOR, advance the index; -> BODY, or -> EOF if this was the last byte.
  - EOF: o_byte=FLAG_BYTE, o_frame_done=1 -> GAP.
  - GAP: o_byte=IDLE_BYTE -> IDLE.
- Latency: the first flag appears on o_byte in the cycle following the accept edge.
- Frame length, flag to flag inclusive: 2 + (1+PAYLOAD_BYTES) + E bytes, where E is the number of escaped bytes. For default parameters with no escapes this is 7 bytes, followed by 1 GAP byte.
- Back-to-back with i_valid held high:
  - The next accept happens at the end of the IDLE cycle after GAP, so frames are separated by exactly two IDLE_BYTEs.
  - Unescaped period is 9 cycles.
- The 0x00 byte is a legal data value: it is emitted unescaped inside a frame.
- Stuffing never emits a bare FLAG_BYTE between the two delimiters.
- Arithmetic: index counter is $clog2(PAYLOAD_BYTES+2) bits, no wrap. The shift register shifts left by 8 per consumed byte.

Test Plan:
- Basic frame: x=1, y=0, payload 0x12345678 -> o_byte sequence 7E 10 12 34 56 78 7E 00. o_frame_done high only on the second 7E. o_ready low for exactly 8 cycles.
- Escaping: dest 0x7E, payload 0x7D007E01 -> 7E 7D 5E 7D 5D 00 7D 5E 01 7E 00.
- Worst-case stuffing: dest 0x7D, payload 0x7E7E7E7E -> 7E 7D 5D (7D 5E)x4 7E 00. Flag-to-flag length is 12 bytes.
- Back-to-back: i_valid held high with packets {0xAA, 0xDEADBEEF} then {0xBB, 0xCAFEBABE} -> two complete frames separated by exactly 00 00. Both frames are accepted; no bytes are lost.
- Busy ignore: pulse i_valid with {0xCC, 0x01234567} while a frame is in progress -> not accepted; only the original frame appears on the link.
- Reset mid-frame: assert rst after the third body byte -> o_byte=00 and o_ready=1 immediately. The next packet produces a clean, complete frame. The router deframer drops the truncated frame, and its scoreboard sees only the complete packets.
